// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      DRAIN    = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam int DEF_DRAIN_CYCLES = 4;
   localparam int DEF_MEM_TIMEOUT  = 16;
   localparam int DEF_CNT_W        = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic pc_sel_branch;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } ctrl_t;

   // Bit order matches the field order above: pc_en, pc_sel, 4 enables, 4 flushes.
   localparam ctrl_t CTRL_DRAIN    = ctrl_t'(10'b00_1111_1111);
   localparam ctrl_t CTRL_NORMAL   = ctrl_t'(10'b10_1111_0000);
   localparam ctrl_t CTRL_FREEZE   = ctrl_t'(10'b00_0001_0001);
   localparam ctrl_t CTRL_BRANCH   = ctrl_t'(10'b11_1111_1110);
   localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(10'b00_0111_0100);

   // Stage controls when no freeze applies: branch beats load-use.
   function automatic ctrl_t ctrl_release(input logic branch, input logic load_use);
      if (branch)
         return CTRL_BRANCH;
      else if (load_use)
         return CTRL_LOAD_USE;
      else
         return CTRL_NORMAL;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID/EX load and the IF/ID reader.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rt,
   input  logic       ex_mem_read,
   output logic       load_use
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = id_uses_rt && (ex_rt == id_rt);
      // $zero is never a real producer, so a load into it cannot hazard.
      load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable/flush sequencing for the 5-stage pipeline: drain, hazards, memory freeze.
//
// state    | meaning
// DRAIN    | post-reset flush of every buffer, PC held, DRAIN_CYCLES long
// RUN      | normal issue; resolves freeze > branch > load-use
// MEM_WAIT | pipeline frozen until dmem_ready or MEM_TIMEOUT
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mem_read,
   input  logic             mem_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             pc_sel_branch,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int SEQ_MAX = (DRAIN_CYCLES > MEM_TIMEOUT) ? DRAIN_CYCLES : MEM_TIMEOUT;
   localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

   localparam logic [SEQ_W-1:0] SEQ_ONE     = SEQ_W'(1);
   localparam logic [SEQ_W-1:0] DRAIN_LAST  = SEQ_W'(DRAIN_CYCLES - 1);
   localparam logic [SEQ_W-1:0] TIMEOUT_VAL = SEQ_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q;
   state_t           state_d;
   logic [SEQ_W-1:0] seq_cnt_q;
   logic [SEQ_W-1:0] seq_cnt_d;

   logic  load_use;
   logic  freeze_req;
   logic  wait_done;
   ctrl_t ctrl;
   logic  stall_inc;
   logic  flush_inc;
   logic  timeout_set;

   hazard_detect u_hazard_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_rt       (ex_rt),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   assign freeze_req = dmem_req && !dmem_ready;
   assign wait_done  = dmem_ready || (seq_cnt_q == TIMEOUT_VAL);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= DRAIN;
         seq_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         seq_cnt_q <= seq_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      seq_cnt_d = seq_cnt_q;
      case (state_q)
         DRAIN: begin
            if (seq_cnt_q == DRAIN_LAST) begin
               state_d   = RUN;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + SEQ_ONE;
            end
         end
         RUN: begin
            if (freeze_req) begin
               state_d   = MEM_WAIT;
               seq_cnt_d = SEQ_ONE;
            end
         end
         MEM_WAIT: begin
            if (wait_done) begin
               state_d   = RUN;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + SEQ_ONE;
            end
         end
         default: begin
            state_d   = DRAIN;
            seq_cnt_d = '0;
         end
      endcase
   end

   // RST forces drain controls directly so the buffers are cleared before the first edge.
   always_comb begin
      ctrl        = CTRL_DRAIN;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      timeout_set = 1'b0;
      if (!RST) begin
         case (state_q)
            DRAIN: ctrl = CTRL_DRAIN;
            RUN: begin
               if (freeze_req) begin
                  ctrl      = CTRL_FREEZE;
                  stall_inc = 1'b1;
               end else begin
                  ctrl      = ctrl_release(mem_branch_taken, load_use);
                  stall_inc = !mem_branch_taken && load_use;
                  flush_inc = mem_branch_taken;
               end
            end
            MEM_WAIT: begin
               if (!wait_done) begin
                  ctrl      = CTRL_FREEZE;
                  stall_inc = 1'b1;
               end else begin
                  ctrl        = ctrl_release(mem_branch_taken, load_use);
                  stall_inc   = !mem_branch_taken && load_use;
                  flush_inc   = mem_branch_taken;
                  timeout_set = !dmem_ready;
               end
            end
            default: ctrl = CTRL_DRAIN;
         endcase
      end
   end

   assign pc_en         = ctrl.pc_en;
   assign pc_sel_branch = ctrl.pc_sel_branch;
   assign ifid_en       = ctrl.ifid_en;
   assign idex_en       = ctrl.idex_en;
   assign exmem_en      = ctrl.exmem_en;
   assign memwb_en      = ctrl.memwb_en;
   assign ifid_flush    = ctrl.ifid_flush;
   assign idex_flush    = ctrl.idex_flush;
   assign exmem_flush   = ctrl.exmem_flush;
   assign memwb_flush   = ctrl.memwb_flush;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_ONE;
         if (timeout_set)
            mem_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (default build plus a 4-bit counter build).
module tb_pipeline_hazard_ctrl;

   localparam logic [9:0] E_DRN  = 10'b00_1111_1111;
   localparam logic [9:0] E_NORM = 10'b10_1111_0000;
   localparam logic [9:0] E_FRZ  = 10'b00_0001_0001;
   localparam logic [9:0] E_BR   = 10'b11_1111_1110;
   localparam logic [9:0] E_LU   = 10'b00_0111_0100;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
   logic       dmem_req = 1'b0, dmem_ready = 1'b0;

   logic        pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_pc_sel_branch, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_mem_timeout;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   wire [9:0] ctrl   = {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_flush, idex_flush, exmem_flush, memwb_flush};
   wire [9:0] s_ctrl = {s_pc_en, s_pc_sel_branch, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush};

   pipeline_hazard_ctrl dut (
      .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en),
      .pc_sel_branch(pc_sel_branch), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(s_pc_en),
      .pc_sel_branch(s_pc_sel_branch), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
      .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
      .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush),
      .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [9:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   st = 0;
   int   fl = 0;
   logic to_exp = 1'b0;

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus; expected stage controls go through the scoreboard.
   task automatic step(input logic rst, input logic req, input logic rdy, input logic br,
                       input logic mr, input logic urt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] ert,
                       input logic [9:0] exp, input string tag);
      exp_t e;
      @(posedge CLK);
      #1;
      RST = rst; dmem_req = req; dmem_ready = rdy; mem_branch_taken = br;
      ex_mem_read = mr; id_uses_rt = urt; id_rs = rs; id_rt = rt; ex_rt = ert;
      sb.push_back('{tag, exp});
      @(negedge CLK);
      e = sb.pop_front();
      chk({e.tag, "_ctrl"}, 32'(ctrl), 32'(e.exp));
      chk({e.tag, "_ctrl_w4"}, 32'(s_ctrl), 32'(e.exp));
   endtask

   task automatic idle(input logic [9:0] exp, input string tag);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, exp, tag);
   endtask

   task automatic lu(input logic br, input logic [9:0] exp, input string tag);
      step(1'b0, 1'b0, 1'b0, br, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5, exp, tag);
   endtask

   task automatic mem(input logic rst, input logic rdy, input logic br,
                      input logic [9:0] exp, input string tag);
      step(rst, 1'b1, rdy, br, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, exp, tag);
   endtask

   // Counters reflect the cycle just completed; the following cycle is idle.
   task automatic cnt_check(input string tag);
      @(posedge CLK);
      #1;
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(sat(st, 65535)));
      chk({tag, "_flush"}, 32'(flush_cnt), 32'(sat(fl, 65535)));
      chk({tag, "_timeout"}, 32'(mem_timeout), 32'(to_exp));
      chk({tag, "_stall_w4"}, 32'(s_stall_cnt), 32'(sat(st, 15)));
      RST = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; mem_branch_taken = 1'b0;
      ex_mem_read = 1'b0; id_uses_rt = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
   endtask

   task automatic drain_then_run(input string tag);
      for (int i = 0; i < 4; i++) idle(E_DRN, {tag, "_drain"});
      idle(E_NORM, {tag, "_run"});
   endtask

   initial begin
      // Power-on reset held for two edges, then the drain.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_DRN, "rst0");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_DRN, "rst1");
      drain_then_run("por");
      cnt_check("por");

      lu(1'b0, E_LU, "lu_rs"); st++;
      cnt_check("lu_rs");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, E_NORM, "lu_zero");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd7, 5'd7, E_LU, "lu_rt"); st++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 5'd7, E_NORM, "lu_rt_unused");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5, E_NORM, "no_load");
      cnt_check("lu_mix");

      lu(1'b1, E_BR, "br_lu"); fl++;
      cnt_check("br_lu");

      for (int i = 0; i < 3; i++) mem(1'b0, 1'b0, 1'b0, E_FRZ, "wait3");
      mem(1'b0, 1'b1, 1'b0, E_NORM, "wait3_rel"); st += 3;
      cnt_check("wait3");

      mem(1'b0, 1'b0, 1'b1, E_FRZ, "frz_br");
      mem(1'b0, 1'b1, 1'b1, E_BR, "frz_br_rel"); st += 1; fl++;
      cnt_check("frz_br");

      for (int i = 0; i < 16; i++) mem(1'b0, 1'b0, 1'b0, E_FRZ, "tmo");
      mem(1'b0, 1'b0, 1'b0, E_NORM, "tmo_rel"); st += 16; to_exp = 1'b1;
      cnt_check("tmo");
      for (int i = 0; i < 3; i++) idle(E_NORM, "tmo_after");
      cnt_check("tmo_sticky");

      // Reset in the middle of a wait clears everything and restarts the drain.
      mem(1'b0, 1'b0, 1'b0, E_FRZ, "midwait");
      mem(1'b1, 1'b0, 1'b0, E_DRN, "midwait_rst");
      st = 0; fl = 0; to_exp = 1'b0;
      drain_then_run("midwait");
      cnt_check("midwait");

      // Reset in the middle of the drain must restart the full drain length.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_DRN, "middrn_rst0");
      idle(E_DRN, "middrn_a");
      idle(E_DRN, "middrn_b");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, E_DRN, "middrn_rst1");
      drain_then_run("middrn");

      for (int i = 0; i < 20; i++) lu(1'b0, E_LU, "sat_lu");
      st += 20;
      cnt_check("sat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
